// File: rtl/my9262_rx_monitor.sv
// my9262_rx_monitor: receive-side monitor / bus sniffer for the MY9262 serial LED-driver link.
// Oversamples Lat/Dclk/Di/Gck in the CLK_240M domain, rebuilds 16-bit words shifted in on
// Dclk rises, classifies each Lat pulse by the Dclk rises seen while Lat is high, and
// counts Gck rises.
//
// state  | meaning
// IDLE   | no bits received since the last report
// SHIFT  | receiving bits, Lat low
// LATCH  | Lat high; every Dclk rise is also counted as a latch edge
// REPORT | one cycle: publish the latch summary and clear the frame counters
module my9262_rx_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_EDGES  = 3,
  parameter int CFG_EDGES   = 11
) (
  input  logic        CLK_240M,
  input  logic        RST_N,
  input  logic        my9262_Lat,
  input  logic        my9262_Dclk,
  input  logic        my9262_Di,
  input  logic        my9262_Gck,
  output logic [15:0] rx_Data,
  output logic        rx_Data_Valid,
  output logic        rx_Cmd_Valid,
  output logic [1:0]  rx_Cmd_Type,
  output logic [4:0]  rx_Cmd_Edges,
  output logic [9:0]  rx_Word_Count,
  output logic [3:0]  rx_Bit_Residue,
  output logic [15:0] rx_Gck_Count
);

  localparam logic [4:0] DataEdgesC = 5'(DATA_EDGES);
  localparam logic [4:0] CfgEdgesC  = 5'(CFG_EDGES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LATCH  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // Pin bundle ordering: [3]=Gck [2]=Di [1]=Dclk [0]=Lat
  logic [3:0]                   pins_s;
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic [3:0]                   last_s;
  // History flops for the edge-detected lines only: [2]=Gck [1]=Dclk [0]=Lat
  logic [2:0]                   hist_q;

  logic lat_rise;
  logic lat_fall;
  logic dclk_rise;
  logic gck_rise;
  logic di_s;

  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  word_cnt_q, word_cnt_d;
  logic [4:0]  edge_cnt_q, edge_cnt_d;

  logic [15:0] rx_data_q, rx_data_d;
  logic        data_valid_q, data_valid_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [1:0]  cmd_type_q, cmd_type_d;
  logic [4:0]  cmd_edges_q, cmd_edges_d;
  logic [9:0]  word_rpt_q, word_rpt_d;
  logic [3:0]  residue_q, residue_d;
  logic [15:0] rx_gck_cnt_q;

  assign pins_s = {my9262_Gck, my9262_Di, my9262_Dclk, my9262_Lat};
  assign last_s = sync_q[SYNC_STAGES-1];

  // Di is taken from the same stage as the Dclk edge so both see identical delay.
  assign lat_rise  =  last_s[0] & ~hist_q[0];
  assign lat_fall  = ~last_s[0] &  hist_q[0];
  assign dclk_rise =  last_s[1] & ~hist_q[1];
  assign di_s      =  last_s[2];
  assign gck_rise  =  last_s[3] & ~hist_q[2];

  // Input synchroniser chain plus one history stage for edge detection.
  always_ff @(posedge CLK_240M or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins_s};
      hist_q <= {last_s[3], last_s[1], last_s[0]};
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_240M or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, frame counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    rx_data_d    = rx_data_q;
    data_valid_d = 1'b0;
    cmd_valid_d  = 1'b0;
    cmd_type_d   = cmd_type_q;
    cmd_edges_d  = cmd_edges_q;
    word_rpt_d   = word_rpt_q;
    residue_d    = residue_q;

    // Shifting runs in every state; a rise during REPORT starts the next frame's count.
    if (dclk_rise) begin
      shift_d = {shift_q[14:0], di_s};
      if (state_q == ST_REPORT) begin
        bit_cnt_d = 4'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'hF) begin
          rx_data_d    = {shift_q[14:0], di_s};
          data_valid_d = 1'b1;
          if (word_cnt_q != 10'h3FF) begin
            word_cnt_d = word_cnt_q + 10'd1;
          end
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (lat_rise) begin
          state_d    = ST_LATCH;
          edge_cnt_d = {4'd0, dclk_rise};
        end else if (dclk_rise) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (lat_rise) begin
          state_d    = ST_LATCH;
          edge_cnt_d = {4'd0, dclk_rise};
        end
      end
      ST_LATCH: begin
        // A rise coincident with the Lat fall is still counted before reporting.
        if (dclk_rise && (edge_cnt_q != 5'd31)) begin
          edge_cnt_d = edge_cnt_q + 5'd1;
        end
        if (lat_fall) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        cmd_valid_d = 1'b1;
        cmd_edges_d = edge_cnt_q;
        word_rpt_d  = word_cnt_q;
        residue_d   = bit_cnt_q;
        if (edge_cnt_q == CfgEdgesC) begin
          cmd_type_d = 2'd2;
        end else if (edge_cnt_q == DataEdgesC) begin
          cmd_type_d = 2'd1;
        end else begin
          cmd_type_d = 2'd0;
        end
        edge_cnt_d = 5'd0;
        word_cnt_d = 10'd0;
        if (!dclk_rise) begin
          bit_cnt_d = 4'd0;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK_240M or negedge RST_N) begin
    if (!RST_N) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      rx_data_q    <= '0;
      data_valid_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_type_q   <= '0;
      cmd_edges_q  <= '0;
      word_rpt_q   <= '0;
      residue_q    <= '0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      rx_data_q    <= rx_data_d;
      data_valid_q <= data_valid_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_type_q   <= cmd_type_d;
      cmd_edges_q  <= cmd_edges_d;
      word_rpt_q   <= word_rpt_d;
      residue_q    <= residue_d;
    end
  end

  // Free-running Gck rise counter, wraps at 2^16, independent of the FSM.
  always_ff @(posedge CLK_240M or negedge RST_N) begin
    if (!RST_N) begin
      rx_gck_cnt_q <= '0;
    end else if (gck_rise) begin
      rx_gck_cnt_q <= rx_gck_cnt_q + 16'd1;
    end
  end

  assign rx_Data        = rx_data_q;
  assign rx_Data_Valid  = data_valid_q;
  assign rx_Cmd_Valid   = cmd_valid_q;
  assign rx_Cmd_Type    = cmd_type_q;
  assign rx_Cmd_Edges   = cmd_edges_q;
  assign rx_Word_Count  = word_rpt_q;
  assign rx_Bit_Residue = residue_q;
  assign rx_Gck_Count   = rx_gck_cnt_q;

endmodule

// File: tb/tb_my9262_rx_monitor.sv
`timescale 1ns/1ps
// Bench for my9262_rx_monitor: drives the serial bus at the pins, pushes expected words and
// latch reports into queues, and compares them with what the DUT publishes.
module tb_my9262_rx_monitor;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        lat   = 1'b0;
  logic        dclk  = 1'b0;
  logic        di    = 1'b0;
  logic        gck   = 1'b0;

  logic [15:0] rx_data;
  logic        rx_data_valid;
  logic        rx_cmd_valid;
  logic [1:0]  rx_cmd_type;
  logic [4:0]  rx_cmd_edges;
  logic [9:0]  rx_word_count;
  logic [3:0]  rx_bit_residue;
  logic [15:0] rx_gck_count;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int gck_model = 0;

  // Report packing: {edges[4:0], type[1:0], words[9:0], residue[3:0]}
  logic [15:0] exp_data[$];
  logic [15:0] obs_data[$];
  logic [20:0] exp_rpt[$];
  logic [20:0] obs_rpt[$];
  int          obs_data_cyc[$];
  int          obs_rpt_cyc[$];

  always #2 clk = ~clk;

  my9262_rx_monitor #(.SYNC_STAGES(2), .DATA_EDGES(3), .CFG_EDGES(11)) dut (
    .CLK_240M       (clk),
    .RST_N          (rst_n),
    .my9262_Lat     (lat),
    .my9262_Dclk    (dclk),
    .my9262_Di      (di),
    .my9262_Gck     (gck),
    .rx_Data        (rx_data),
    .rx_Data_Valid  (rx_data_valid),
    .rx_Cmd_Valid   (rx_cmd_valid),
    .rx_Cmd_Type    (rx_cmd_type),
    .rx_Cmd_Edges   (rx_cmd_edges),
    .rx_Word_Count  (rx_word_count),
    .rx_Bit_Residue (rx_bit_residue),
    .rx_Gck_Count   (rx_gck_count)
  );

  // Output capture on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (rx_data_valid) begin
        obs_data.push_back(rx_data);
        obs_data_cyc.push_back(cyc);
      end
      if (rx_cmd_valid) begin
        obs_rpt.push_back({rx_cmd_edges, rx_cmd_type, rx_word_count, rx_bit_residue});
        obs_rpt_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [20:0] rpt(input int edges, input int typ, input int words, input int res);
    logic [4:0] e;
    logic [1:0] t;
    logic [9:0] w;
    logic [3:0] r;
    e = 5'(edges);
    t = 2'(typ);
    w = 10'(words);
    r = 4'(res);
    return {e, t, w, r};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input int half);
    di   = b;
    dclk = 1'b0;
    cycles(half);
    dclk = 1'b1;
    cycles(half);
  endtask

  task automatic send_word(input logic [15:0] w, input int lat_from, input int half);
    for (int i = 0; i < 16; i++) begin
      if (i == lat_from) lat = 1'b1;
      clock_bit(w[15-i], half);
    end
  endtask

  task automatic end_lat(input int half);
    dclk = 1'b0;
    cycles(half);
    lat = 1'b0;
    cycles(8);
  endtask

  task automatic lat_pulse_only();
    dclk = 1'b0;
    cycles(4);
    lat = 1'b1;
    cycles(4);
    lat = 1'b0;
    cycles(8);
  endtask

  task automatic gck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      gck = 1'b1;
      cycles(2);
      gck = 1'b0;
      cycles(2);
      gck_model = gck_model + 1;
    end
  endtask

  // Bounded wait until the capture queues hold at least nd words and nr reports.
  task automatic wait_obs(input int nd, input int nr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (obs_data.size() >= nd && obs_rpt.size() >= nr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cycles(4);
  endtask

  task automatic test_reset();
    bit ok;
    logic [15:0] e16, g16;
    logic [20:0] er, gr;
    rst_n = 1'b0;
    cycles(4);
    rst_n = 1'b1;
    cycles(4);
    gck_pulses(3);
    cycles(6);
    n_cmp++;
    if (rx_gck_count !== 16'(gck_model)) begin
      n_mis++;
      $display("FAIL reset_pre_gck: got %0d required %0d", rx_gck_count, gck_model);
    end
    for (int i = 0; i < 7; i++) clock_bit(i[0], 2);
    di   = 1'b1;
    dclk = 1'b0;
    cycles(2);
    dclk  = 1'b1;
    rst_n = 1'b0;
    cycles(2);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 2);
    gck_model = 0;
    n_cmp++;
    if (rx_data !== 16'h0) begin
      n_mis++;
      $display("FAIL reset_rx_data: got %h required 0000", rx_data);
    end
    n_cmp++;
    if ({rx_data_valid, rx_cmd_valid, rx_cmd_type, rx_cmd_edges, rx_word_count, rx_bit_residue} !== 23'h0) begin
      n_mis++;
      $display("FAIL reset_ctrl_outs: dv=%b cv=%b type=%0d edges=%0d words=%0d res=%0d required all 0",
               rx_data_valid, rx_cmd_valid, rx_cmd_type, rx_cmd_edges, rx_word_count, rx_bit_residue);
    end
    n_cmp++;
    if (rx_gck_count !== 16'h0) begin
      n_mis++;
      $display("FAIL reset_gck: got %0d required 0", rx_gck_count);
    end
    dclk = 1'b0;
    cycles(4);
    rst_n = 1'b1;
    cycles(6);
    exp_data.push_back(16'hA5A5);
    send_word(16'hA5A5, -1, 2);
    exp_rpt.push_back(rpt(0, 0, 1, 0));
    lat_pulse_only();
    wait_obs(1, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL reset_timeout: got %0d words %0d reports required 1 and 1", obs_data.size(), obs_rpt.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e16 = exp_data.pop_front();
      g16 = obs_data.pop_front();
      n_cmp++;
      if (g16 !== e16) begin
        n_mis++;
        $display("FAIL reset_after_word: got %h required %h", g16, e16);
      end
    end
    while (exp_rpt.size() > 0 && obs_rpt.size() > 0) begin
      er = exp_rpt.pop_front();
      gr = obs_rpt.pop_front();
      n_cmp++;
      if (gr !== er) begin
        n_mis++;
        $display("FAIL reset_flush_report: got %h required %h", gr, er);
      end
    end
    n_cmp++;
    if (obs_data.size() + obs_rpt.size() + exp_data.size() + exp_rpt.size() != 0) begin
      n_mis++;
      $display("FAIL reset_leftover: got %0d unmatched entries required 0",
               obs_data.size() + obs_rpt.size() + exp_data.size() + exp_rpt.size());
    end
    exp_data.delete(); obs_data.delete(); exp_rpt.delete(); obs_rpt.delete();
    obs_data_cyc.delete(); obs_rpt_cyc.delete();
  endtask

  task automatic test_config_latch();
    bit ok;
    logic [15:0] e16, g16;
    logic [20:0] er, gr;
    exp_data.push_back(16'h0EA0);
    exp_rpt.push_back(rpt(11, 2, 1, 0));
    send_word(16'h0EA0, 5, 4);
    end_lat(4);
    wait_obs(1, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL cfg_timeout: got %0d words %0d reports required 1 and 1", obs_data.size(), obs_rpt.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e16 = exp_data.pop_front();
      g16 = obs_data.pop_front();
      n_cmp++;
      if (g16 !== e16) begin
        n_mis++;
        $display("FAIL cfg_word: got %h required %h", g16, e16);
      end
    end
    while (exp_rpt.size() > 0 && obs_rpt.size() > 0) begin
      er = exp_rpt.pop_front();
      gr = obs_rpt.pop_front();
      n_cmp++;
      if (gr !== er) begin
        n_mis++;
        $display("FAIL cfg_report: got edges=%0d type=%0d words=%0d res=%0d required edges=%0d type=%0d words=%0d res=%0d",
                 gr[20:16], gr[15:14], gr[13:4], gr[3:0], er[20:16], er[15:14], er[13:4], er[3:0]);
      end
    end
    n_cmp++;
    if (obs_data.size() + obs_rpt.size() != 0) begin
      n_mis++;
      $display("FAIL cfg_extra_outputs: got %0d extra required 0", obs_data.size() + obs_rpt.size());
    end
    exp_data.delete(); obs_data.delete(); exp_rpt.delete(); obs_rpt.delete();
    obs_data_cyc.delete(); obs_rpt_cyc.delete();
  endtask

  task automatic test_data_stream();
    bit ok;
    logic [15:0] e16, g16;
    logic [20:0] er, gr;
    int k;
    for (int w = 0; w < 16; w++) begin
      exp_data.push_back(16'(w));
      send_word(16'(w), (w == 15) ? 13 : -1, 2);
    end
    exp_rpt.push_back(rpt(3, 1, 16, 0));
    end_lat(2);
    wait_obs(16, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL stream_timeout: got %0d words %0d reports required 16 and 1", obs_data.size(), obs_rpt.size());
    end
    k = 0;
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e16 = exp_data.pop_front();
      g16 = obs_data.pop_front();
      n_cmp++;
      if (g16 !== e16) begin
        n_mis++;
        $display("FAIL stream_word[%0d]: got %h required %h", k, g16, e16);
      end
      k++;
    end
    while (exp_rpt.size() > 0 && obs_rpt.size() > 0) begin
      er = exp_rpt.pop_front();
      gr = obs_rpt.pop_front();
      n_cmp++;
      if (gr !== er) begin
        n_mis++;
        $display("FAIL stream_report: got edges=%0d type=%0d words=%0d res=%0d required edges=%0d type=%0d words=%0d res=%0d",
                 gr[20:16], gr[15:14], gr[13:4], gr[3:0], er[20:16], er[15:14], er[13:4], er[3:0]);
      end
    end
    n_cmp++;
    if (obs_data.size() + obs_rpt.size() + exp_data.size() != 0) begin
      n_mis++;
      $display("FAIL stream_leftover: got %0d unmatched required 0", obs_data.size() + obs_rpt.size() + exp_data.size());
    end
    exp_data.delete(); obs_data.delete(); exp_rpt.delete(); obs_rpt.delete();
    obs_data_cyc.delete(); obs_rpt_cyc.delete();
  endtask

  task automatic test_residue();
    bit ok;
    logic [15:0] e16, g16;
    logic [20:0] er, gr;
    exp_data.push_back(16'hC3A5);
    send_word(16'hC3A5, -1, 2);
    clock_bit(1'b1, 2);
    clock_bit(1'b0, 2);
    clock_bit(1'b1, 2);
    clock_bit(1'b1, 2);
    exp_rpt.push_back(rpt(0, 0, 1, 4));
    lat_pulse_only();
    wait_obs(1, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL residue_timeout: got %0d words %0d reports required 1 and 1", obs_data.size(), obs_rpt.size());
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e16 = exp_data.pop_front();
      g16 = obs_data.pop_front();
      n_cmp++;
      if (g16 !== e16) begin
        n_mis++;
        $display("FAIL residue_word: got %h required %h", g16, e16);
      end
    end
    while (exp_rpt.size() > 0 && obs_rpt.size() > 0) begin
      er = exp_rpt.pop_front();
      gr = obs_rpt.pop_front();
      n_cmp++;
      if (gr !== er) begin
        n_mis++;
        $display("FAIL residue_report: got edges=%0d type=%0d words=%0d res=%0d required edges=%0d type=%0d words=%0d res=%0d",
                 gr[20:16], gr[15:14], gr[13:4], gr[3:0], er[20:16], er[15:14], er[13:4], er[3:0]);
      end
    end
    exp_data.delete(); obs_data.delete(); exp_rpt.delete(); obs_rpt.delete();
    obs_data_cyc.delete(); obs_rpt_cyc.delete();
  endtask

  task automatic test_coincident_fall();
    bit ok;
    logic [15:0] w, e16, g16;
    logic [20:0] er, gr;
    int dcyc, rcyc;
    w = 16'h5A3C;
    exp_data.push_back(w);
    exp_rpt.push_back(rpt(3, 1, 1, 0));
    for (int i = 0; i < 15; i++) begin
      if (i == 13) lat = 1'b1;
      clock_bit(w[15-i], 2);
    end
    di   = w[0];
    dclk = 1'b0;
    cycles(2);
    dclk = 1'b1;
    lat  = 1'b0;
    cycles(2);
    dclk = 1'b0;
    cycles(6);
    wait_obs(1, 1, ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL coinc_timeout: got %0d words %0d reports required 1 and 1", obs_data.size(), obs_rpt.size());
    end
    if (ok) begin
      dcyc = obs_data_cyc[0];
      rcyc = obs_rpt_cyc[0];
      n_cmp++;
      if (!(dcyc < rcyc)) begin
        n_mis++;
        $display("FAIL coinc_order: data_valid at %0d cmd_valid at %0d required data before cmd", dcyc, rcyc);
      end
    end
    while (exp_data.size() > 0 && obs_data.size() > 0) begin
      e16 = exp_data.pop_front();
      g16 = obs_data.pop_front();
      n_cmp++;
      if (g16 !== e16) begin
        n_mis++;
        $display("FAIL coinc_word: got %h required %h", g16, e16);
      end
    end
    while (exp_rpt.size() > 0 && obs_rpt.size() > 0) begin
      er = exp_rpt.pop_front();
      gr = obs_rpt.pop_front();
      n_cmp++;
      if (gr !== er) begin
        n_mis++;
        $display("FAIL coinc_report: got edges=%0d type=%0d words=%0d res=%0d required edges=%0d type=%0d words=%0d res=%0d",
                 gr[20:16], gr[15:14], gr[13:4], gr[3:0], er[20:16], er[15:14], er[13:4], er[3:0]);
      end
    end
    exp_data.delete(); obs_data.delete(); exp_rpt.delete(); obs_rpt.delete();
    obs_data_cyc.delete(); obs_rpt_cyc.delete();
  endtask

  task automatic test_gck_wrap();
    gck_pulses(100);
    cycles(6);
    n_cmp++;
    if (rx_gck_count !== 16'(gck_model)) begin
      n_mis++;
      $display("FAIL gck_100: got %0d required %0d", rx_gck_count, gck_model);
    end
    // Preload near the top so the wrap is reached in a short run.
    force dut.rx_gck_cnt_q = 16'hFFFC;
    cycles(1);
    release dut.rx_gck_cnt_q;
    cycles(1);
    gck_model = 16'hFFFC;
    gck_pulses(104);
    cycles(6);
    n_cmp++;
    if (rx_gck_count !== 16'(gck_model)) begin
      n_mis++;
      $display("FAIL gck_wrap: got %0d required %0d", rx_gck_count, 16'(gck_model));
    end
    n_cmp++;
    if (obs_data.size() + obs_rpt.size() != 0) begin
      n_mis++;
      $display("FAIL gck_side_effects: got %0d bus outputs required 0", obs_data.size() + obs_rpt.size());
    end
  endtask

  initial begin
    test_reset();
    test_config_latch();
    test_data_stream();
    test_residue();
    test_coincident_fall();
    test_gck_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
